msg_schedule: RTL and testbench
===============================

// Module: msg_schedule
// PURPOSE
//  SHA-256 message-schedule stage. Accepts one 512-bit block as 16 x 32-bit words over a valid/ready handshake.
//  Emits W_0..W_63, one per cycle, to the compression round. Drives the address/enable of the round-constant ROM
//  one cycle early, so K_t (registered in the ROM) and W_t reach the round datapath in the same cycle.
// PARAMETERS
//  WRD_SIZE   32  word width (algorithm fixed at 32; other values unsupported)
//  ADDR_WTH   6   round-index width (64 rounds)
//  NUM_WORDS  16  words per block / schedule window depth
// PORTS
//  clk           in   1         clock; all state on rising edge
//  reset         in   1         asynchronous, active-high reset
//  i_word_valid  in   1         input word valid
//  i_word        in   WRD_SIZE  message word, big-endian order, M_0 first
//  o_word_ready  out  1         stage accepts a word (LOAD state only)
//  o_rc_add      out  ADDR_WTH  round-constant ROM address
//  o_rc_en       out  1         round-constant ROM enable
//  o_w           out  WRD_SIZE  schedule word W_t (registered)
//  o_w_idx       out  ADDR_WTH  round index t of o_w (registered)
//  o_w_valid     out  1         o_w/o_w_idx valid; K_t on ROM output in same cycle
//  o_done        out  1         1-cycle pulse when W_63 is consumed
//  i_stall       in   1         only with MSG_SCHED_STALL_EN; freeze schedule advance
// BEHAVIOUR
//  Reset (any time, incl. mid-block): state=LOAD, load count=0, issue ptr=0, window cleared.
//   o_w=0, o_w_idx=0, o_w_valid=0, o_rc_en=0, o_rc_add=0, o_done=0. A partial block is discarded.
//  FSM LOAD -> RUN -> DRAIN -> LOAD.
//  LOAD: o_word_ready=1. A word is accepted when valid&ready and shifts into the 16-entry window.
//   After the 16th accept the FSM moves to RUN with issue ptr t=0. o_rc_en=0, o_w_valid=0.
//  RUN, issue cycle for round t: o_rc_add=t, o_rc_en=1. W_t is computed combinationally and registered into o_w.
//   o_w_idx=t and o_w_valid=1 take effect on the next edge (1-cycle latency, matching the ROM).
//  W rule: t<16: W_t = M_t.
//   t>=16: W_t = s1(W_{t-2}) + W_{t-7} + s0(W_{t-15}) + W_{t-16}, taken mod 2^32; carries are dropped.
//   s0(x) = ROTR7 ^ ROTR18 ^ SHR3.  s1(x) = ROTR17 ^ ROTR19 ^ SHR10.
//   The window shifts by one word per issued round (oldest out, W_t in).
//  After issuing t=63, the FSM moves to DRAIN; the issue ptr wraps to 0.
//  DRAIN: o_w=W_63 valid; o_rc_en=0 unless stalled.
//   When not stalled: o_done=1, then LOAD next cycle, where o_w_valid drops to 0.
//  Back-to-back blocks: the first word of the next block can be accepted 1 cycle after o_done.
//  i_word_valid outside LOAD is ignored; no word is lost because o_word_ready=0 there.
//  Throughput: 16 load + 64 run + 1 drain = 81 cycles per block minimum.
// CONFIGURATION
//  MSG_SCHED_STALL_EN defined: the i_stall port exists. The downstream consumes W when o_w_valid & !i_stall.
//   While i_stall=1 and o_w_valid=1: o_w, o_w_idx, window, ptr and state are held.
//   o_rc_add=o_w_idx and o_rc_en=1, so the ROM re-presents the same K_t (the ROM zeroes its output when disabled).
//   o_done stays 0 during stall. i_stall is ignored in LOAD.
//  Undefined: no i_stall port; the schedule advances every cycle unconditionally.
// STRUCTURE
//  Shared package sha_pkg: WRD_SIZE, ADDR_WTH, ROUNDS=64, NUM_WORDS=16, FSM state encoding (LOAD/RUN/DRAIN).
//  Sub-module sha_sigma: combinational s0/s1; 32-bit input x, outputs sig0, sig1.
//  The top holds the FSM, counters, window and output registers.
// TESTING
//  1 "abc" block (61626380, 0 x14, 00000018): W_0=61626380 with ROM K=428a2f98; W_15=00000018.
//    Also W_16=61626380, W_17=000f0000, W_18=7da86405, W_63=12b1edeb (K=c67178f2); o_done 1 pulse.
//  2 Load gaps: i_word_valid toggled 1/0 during load -> exactly 16 accepts; RUN starts the cycle after the 16th accept.
//  3 Back-to-back: 2 "abc" blocks fed continuously -> identical W streams; 2nd block's first accept 1 cycle after o_done.
//  4 Reset mid-RUN at t=30: all outputs 0 the same cycle. A fresh block afterwards gives W_0=61626380.
//  5 (MSG_SCHED_STALL_EN) i_stall=1 for 3 cycles at W_20: o_w, o_w_idx=20 and ROM K=2de92c6f are held; the stream resumes at W_21.
//  6 Words offered during RUN/DRAIN -> ignored, o_word_ready=0; the schedule is unaffected.

Source files
------------

// File: rtl/sha_pkg.sv
// Shared SHA-256 message-schedule definitions: word/index widths, round
// count, window depth and the schedule FSM state encoding.
package sha_pkg;

  localparam int unsigned WRD_SIZE  = 32;
  localparam int unsigned ADDR_WTH  = 6;
  localparam int unsigned ROUNDS    = 64;
  localparam int unsigned NUM_WORDS = 16;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_t;

endpackage

// File: rtl/sha_sigma.sv
// SHA-256 small sigma functions on one 32-bit word.
//   sig0 = ROTR7 ^ ROTR18 ^ SHR3
//   sig1 = ROTR17 ^ ROTR19 ^ SHR10
module sha_sigma
  import sha_pkg::*;
(
  input  logic [WRD_SIZE-1:0] x,
  output logic [WRD_SIZE-1:0] sig0,
  output logic [WRD_SIZE-1:0] sig1
);

  // pure rotate/shift/xor network
  always_comb begin
    sig0 = {x[6:0],  x[31:7]}  ^ {x[17:0], x[31:18]} ^ (x >> 3);
    sig1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  end

endmodule

// File: rtl/msg_schedule.sv
// SHA-256 message-schedule stage. Loads 16 message words, then issues
// W_0..W_63 one per cycle with the round-constant ROM address driven one
// cycle ahead so K_t and W_t line up at the round datapath.
// Optional build macro: MSG_SCHED_STALL_EN adds the i_stall port.
module msg_schedule #(
  parameter int unsigned WRD_SIZE  = sha_pkg::WRD_SIZE,
  parameter int unsigned ADDR_WTH  = sha_pkg::ADDR_WTH,
  parameter int unsigned NUM_WORDS = sha_pkg::NUM_WORDS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_word_valid,
  input  logic [WRD_SIZE-1:0] i_word,
  output logic                o_word_ready,
  output logic [ADDR_WTH-1:0] o_rc_add,
  output logic                o_rc_en,
  output logic [WRD_SIZE-1:0] o_w,
  output logic [ADDR_WTH-1:0] o_w_idx,
  output logic                o_w_valid,
  output logic                o_done
`ifdef MSG_SCHED_STALL_EN
  ,
  input  logic                i_stall
`endif
);

  import sha_pkg::*;

  localparam int unsigned CNT_W = $clog2(NUM_WORDS);

  sched_state_t        state, next_state;
  logic [CNT_W-1:0]    load_cnt;
  logic [ADDR_WTH-1:0] ptr;
  logic [WRD_SIZE-1:0] window [NUM_WORDS];
  logic [WRD_SIZE-1:0] w_next;
  logic [WRD_SIZE-1:0] s0_w1, s1_w14, unused_s1_w1, unused_s0_w14;
  logic                accept, stall;

  assign accept = i_word_valid & (state == ST_LOAD);

`ifdef MSG_SCHED_STALL_EN
  assign stall = i_stall & o_w_valid;
`else
  assign stall = 1'b0;
`endif

  // window[0] is always W_{t-16}; window[1] is W_{t-15}; window[14] is W_{t-2}
  sha_sigma u_sig_old (.x(window[1]),  .sig0(s0_w1),         .sig1(unused_s1_w1));
  sha_sigma u_sig_new (.x(window[14]), .sig0(unused_s0_w14), .sig1(s1_w14));

  // next schedule word: message words pass straight through the window head
  always_comb begin
    if (ptr < ADDR_WTH'(NUM_WORDS))
      w_next = window[0];
    else
      w_next = s1_w14 + window[NUM_WORDS-7] + s0_w1 + window[0];
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_LOAD;
    else       state <= next_state;
  end

  // next-state logic and ROM address/enable, handshake and done outputs
  always_comb begin
    next_state   = state;
    o_word_ready = 1'b0;
    o_rc_add     = '0;
    o_rc_en      = 1'b0;
    o_done       = 1'b0;
    case (state)
      ST_LOAD: begin
        o_word_ready = 1'b1;
        if (accept && (load_cnt == CNT_W'(NUM_WORDS-1))) next_state = ST_RUN;
      end
      ST_RUN: begin
        o_rc_en = 1'b1;
        if (stall) begin
          o_rc_add = o_w_idx;
        end else begin
          o_rc_add = ptr;
          if (ptr == ADDR_WTH'(ROUNDS-1)) next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (stall) begin
          o_rc_add = o_w_idx;
          o_rc_en  = 1'b1;
        end else begin
          o_done     = 1'b1;
          next_state = ST_LOAD;
        end
      end
      default: next_state = ST_LOAD;
    endcase
  end

  // window, counters and registered schedule output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_cnt  <= '0;
      ptr       <= '0;
      o_w       <= '0;
      o_w_idx   <= '0;
      o_w_valid <= 1'b0;
      for (int unsigned i = 0; i < NUM_WORDS; i++) window[i] <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (accept) begin
            load_cnt <= load_cnt + 1'b1;
            for (int unsigned i = 0; i < NUM_WORDS-1; i++) window[i] <= window[i+1];
            window[NUM_WORDS-1] <= i_word;
          end
        end
        ST_RUN: begin
          if (!stall) begin
            o_w       <= w_next;
            o_w_idx   <= ptr;
            o_w_valid <= 1'b1;
            ptr       <= ptr + 1'b1;
            for (int unsigned i = 0; i < NUM_WORDS-1; i++) window[i] <= window[i+1];
            window[NUM_WORDS-1] <= w_next;
          end
        end
        ST_DRAIN: begin
          if (!stall) o_w_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_msg_schedule.sv
// Self-checking bench for msg_schedule: "abc" block schedule, load gaps,
// back-to-back blocks, reset mid-run, words offered outside LOAD, and
// (with MSG_SCHED_STALL_EN) a three-cycle stall.
module tb_msg_schedule;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_word_valid;
  logic [31:0] i_word;
  logic        i_stall;
  logic        o_word_ready;
  logic [5:0]  o_rc_add;
  logic        o_rc_en;
  logic [31:0] o_w;
  logic [5:0]  o_w_idx;
  logic        o_w_valid;
  logic        o_done;

  msg_schedule dut (
    .clk          (clk),
    .reset        (reset),
    .i_word_valid (i_word_valid),
    .i_word       (i_word),
    .o_word_ready (o_word_ready),
    .o_rc_add     (o_rc_add),
    .o_rc_en      (o_rc_en),
    .o_w          (o_w),
    .o_w_idx      (o_w_idx),
    .o_w_valid    (o_w_valid),
    .o_done       (o_done)
`ifdef MSG_SCHED_STALL_EN
    ,
    .i_stall      (i_stall)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // reference schedule for the "abc" block
  logic [31:0] msg   [16];
  logic [31:0] exp_w [64];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // registered round-constant ROM, zero output when disabled
  logic       rom_en_q;
  logic [5:0] rom_addr_q;
  logic [31:0] k_val;

  function automatic logic [31:0] k_of(input logic [5:0] a);
    case (a)
      6'd0:    return 32'h428a2f98;
      6'd20:   return 32'h2de92c6f;
      6'd63:   return 32'hc67178f2;
      default: return 32'h0000_0001;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      rom_en_q   <= o_rc_en;
      rom_addr_q <= o_rc_add;
    end
  end

  assign k_val = rom_en_q ? k_of(rom_addr_q) : 32'h0;

  // stream monitor: checks every consumed word, counts accepts and done pulses
  logic [5:0] exp_idx = '0;
  int n_cons = 0, n_acc = 0, n_done = 0;
  int acc_in_blk = 0, last_done_cyc = -100, first_acc_gap = -1;

  always @(negedge clk) begin
    #1;
    if (reset) begin
      exp_idx    = '0;
      acc_in_blk = 0;
    end else begin
      if (i_word_valid && o_word_ready) begin
        if (acc_in_blk == 0) first_acc_gap = cyc - last_done_cyc;
        acc_in_blk = (acc_in_blk + 1) % 16;
        n_acc++;
      end
      if (o_w_valid && !i_stall) begin
        chk("w_idx", {26'd0, o_w_idx}, {26'd0, exp_idx});
        chk("w_val", o_w, exp_w[o_w_idx]);
        chk("k_addr", {25'd0, rom_en_q, rom_addr_q}, {25'd0, 1'b1, o_w_idx});
        case (o_w_idx)
          6'd0:  begin chk("w0", o_w, 32'h61626380); chk("k0", k_val, 32'h428a2f98); end
          6'd15: chk("w15", o_w, 32'h00000018);
          6'd16: chk("w16", o_w, 32'h61626380);
          6'd17: chk("w17", o_w, 32'h000f0000);
          6'd18: chk("w18", o_w, 32'h7da86405);
          6'd63: begin chk("w63", o_w, 32'h12b1edeb); chk("k63", k_val, 32'hc67178f2); end
          default: ;
        endcase
        exp_idx = exp_idx + 6'd1;
        n_cons++;
      end
      if (o_done) begin
        chk("done_at_63", {25'd0, o_w_valid, o_w_idx}, {25'd0, 1'b1, 6'd63});
        last_done_cyc = cyc;
        n_done++;
      end
    end
  end

  // offer one block; words are driven only when ready, junk otherwise
  task automatic feed_block(input bit gaps);
    int n, guard;
    bit ph;
    n = 0; guard = 0; ph = 1'b0;
    while (n < 16 && guard < 500) begin
      @(negedge clk);
      guard++;
      if (gaps && ph) begin
        i_word_valid = 1'b0;
        i_word       = 32'hdeadbeef;
      end else if (o_word_ready) begin
        i_word_valid = 1'b1;
        i_word       = msg[n];
        n++;
      end else begin
        i_word_valid = 1'b1;
        i_word       = 32'hbad00000 ^ guard;
      end
      ph = ~ph;
    end
    @(negedge clk);
    i_word_valid = 1'b0;
    chk("feed_count", n, 16);
    chk("run_start_en", {31'd0, o_rc_en}, 32'd1);
    chk("run_start_add", {26'd0, o_rc_add}, 32'd0);
    chk("run_rdy_low", {31'd0, o_word_ready}, 32'd0);
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (!o_done && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("done_seen", {31'd0, o_done}, 32'd1);
    @(negedge clk);
    chk("done_pulse", {31'd0, o_done}, 32'd0);
    chk("valid_drop", {31'd0, o_w_valid}, 32'd0);
    chk("ready_back", {31'd0, o_word_ready}, 32'd1);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_w"},     o_w, 32'd0);
    chk({tag, "_idx"},   {26'd0, o_w_idx}, 32'd0);
    chk({tag, "_vld"},   {31'd0, o_w_valid}, 32'd0);
    chk({tag, "_rcen"},  {31'd0, o_rc_en}, 32'd0);
    chk({tag, "_rcadd"}, {26'd0, o_rc_add}, 32'd0);
    chk({tag, "_done"},  {31'd0, o_done}, 32'd0);
    chk({tag, "_rdy"},   {31'd0, o_word_ready}, 32'd1);
  endtask

  initial begin
    int c0, d0, a0, g;

    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
    for (int t = 0; t < 16; t++) exp_w[t] = msg[t];
    for (int t = 16; t < 64; t++)
      exp_w[t] = ss1(exp_w[t-2]) + exp_w[t-7] + ss0(exp_w[t-15]) + exp_w[t-16];

    reset = 1'b1; i_word_valid = 1'b0; i_word = '0; i_stall = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("rst");
    reset = 1'b0;

    // single "abc" block
    c0 = n_cons; d0 = n_done; a0 = n_acc;
    feed_block(1'b0);
    wait_done();
    chk("blk1_cons", n_cons - c0, 64);
    chk("blk1_done", n_done - d0, 1);
    chk("blk1_acc", n_acc - a0, 16);

    // load with valid toggling
    c0 = n_cons; a0 = n_acc;
    feed_block(1'b1);
    wait_done();
    chk("gap_acc", n_acc - a0, 16);
    chk("gap_cons", n_cons - c0, 64);

    // back-to-back blocks with junk offered during RUN/DRAIN
    c0 = n_cons; d0 = n_done; a0 = n_acc;
    feed_block(1'b0);
    feed_block(1'b0);
    chk("b2b_gap", first_acc_gap, 1);
    wait_done();
    chk("b2b_cons", n_cons - c0, 128);
    chk("b2b_done", n_done - d0, 2);
    chk("b2b_acc", n_acc - a0, 32);

    // reset while issuing round 30
    feed_block(1'b0);
    g = 0;
    while (!(o_rc_en && o_rc_add == 6'd30) && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("reach_t30", {26'd0, o_rc_add}, 32'd30);
    reset = 1'b1;
    #1;
    check_idle("midrst");
    @(negedge clk);
    reset = 1'b0;
    c0 = n_cons;
    feed_block(1'b0);
    wait_done();
    chk("post_rst_cons", n_cons - c0, 64);

`ifdef MSG_SCHED_STALL_EN
    // three-cycle stall while W_20 is presented
    feed_block(1'b0);
    g = 0;
    while (!(o_w_valid && o_w_idx == 6'd20) && g < 100) begin
      @(negedge clk);
      g++;
    end
    i_stall = 1'b1;
    repeat (3) begin
      #1;
      chk("stl_idx", {26'd0, o_w_idx}, 32'd20);
      chk("stl_w", o_w, exp_w[20]);
      chk("stl_k", k_val, 32'h2de92c6f);
      chk("stl_rcadd", {26'd0, o_rc_add}, 32'd20);
      chk("stl_rcen", {31'd0, o_rc_en}, 32'd1);
      chk("stl_done", {31'd0, o_done}, 32'd0);
      @(negedge clk);
    end
    i_stall = 1'b0;
    #1;
    chk("stl_rel_idx", {26'd0, o_w_idx}, 32'd20);
    @(negedge clk);
    #1;
    chk("stl_next_idx", {26'd0, o_w_idx}, 32'd21);
    chk("stl_next_w", o_w, exp_w[21]);
    wait_done();
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
